// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab datapaths (multiplier and divider).
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: WIDTH+1-bit trial subtract R' - {0,D} built from
// a ripple chain of add/sub bit cells held in subtract mode (invert B, carry-in 1).
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic [WIDTH:0] w_sub;
    logic [WIDTH:0] w_carry;
    logic [WIDTH:0] w_sum;

    assign w_sub      = ~{1'b0, i_dvs};
    assign w_carry[0] = 1'b1;

    // The carry out of the top cell is never needed: the sign of the
    // WIDTH+1-bit difference already tells whether the subtract went negative.
    for (genvar gi = 0; gi <= WIDTH; gi = gi + 1) begin : g_cell
        assign w_sum[gi] = i_rem[gi] ^ w_sub[gi] ^ w_carry[gi];
        if (gi < WIDTH) begin : g_carry
            assign w_carry[gi+1] = (i_rem[gi] & w_sub[gi]) |
                                   (w_carry[gi] & (i_rem[gi] ^ w_sub[gi]));
        end
    end

    assign o_diff   = w_sum[WIDTH-1:0];
    assign o_borrow = w_sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one trial subtract per clock,
// WIDTH steps per operation, results held until the next completion.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_accept = (r_state == DIV_IDLE) && Start;
    assign w_last   = (r_state == DIV_CALC) && (r_cnt == LAST_STEP);

    // {R,Q} shifted left by one; the partial remainder stays below the divisor,
    // so only its low WIDTH bits need storing between steps.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem    (w_rem_shift),
        .i_dvs    (r_dvs),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_rem_next = w_borrow ? w_rem_shift[WIDTH-1:0] : w_diff;
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (Start) begin
                        r_state <= DIV_CALC;
                        r_cnt   <= '0;
                    end
                end
                DIV_CALC: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Working registers carry no reset; they are always reloaded on acceptance.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_dvs <= Divisor;
            r_quo <= Dividend;
            r_rem <= '0;
        end else if (r_state == DIV_CALC) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end

    // Results load on the final step edge, i.e. the same edge that enters DONE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else if (w_last) begin
            Quotient  <= w_quo_next;
            Remainder <= w_rem_next;
            DivByZero <= (r_dvs == '0);
        end
    end

    assign Busy = (r_state != DIV_IDLE);
    assign Done = (r_state == DIV_DONE);

endmodule
